// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath: decodes the latched opcode,
// drives every select/enable per cycle, handles memory wait states, counts retirements.
module multi_cycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        branch_type_o,
  output logic [1:0]  pc_source_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] retired_o
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_is_bne;
  logic               r_is_lui;
  logic [CNT_W-1:0]   r_retired;

  logic       w_pc_write, w_pc_write_cond, w_branch_type, w_iord;
  logic       w_mem_read, w_mem_write, w_ir_write, w_reg_dst;
  logic       w_mem_to_reg, w_reg_write, w_alu_src_a, w_done, w_illegal;
  logic [1:0] w_pc_source, w_alu_src_b;
  logic [2:0] w_alu_op;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Opcode attributes needed after DECODE, captured once so later IR changes are ignored
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_is_bne <= 1'b0;
      r_is_lui <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_bne <= (instr_op_i == OP_BNE);
      r_is_lui <= (instr_op_i == OP_LUI);
    end
  end

  // Next state and per-state control decode
  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_type   = 1'b0;
    w_pc_source     = 2'b00;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 3'b000;
    w_done          = 1'b0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (instr_op_i)
          OP_R:            w_next = S_R_EXEC;
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          OP_ADDI, OP_LUI: w_next = S_I_EXEC;
          default:         w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (mem_ready_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (mem_ready_i) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 3'b010;
        w_next      = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 3'b001;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_branch_type   = r_is_bne;
        w_done          = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = r_is_lui ? 3'b011 : 3'b000;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      default: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)      r_retired <= '0;
    else if (w_done) r_retired <= r_retired + CNT_W'(1);
  end

  // Reset forces every output low immediately, including the Mealy FETCH strobes
  assign pc_write_o      = rst_n & w_pc_write;
  assign pc_write_cond_o = rst_n & w_pc_write_cond;
  assign branch_type_o   = rst_n & w_branch_type;
  assign pc_source_o     = rst_n ? w_pc_source : 2'b00;
  assign iord_o          = rst_n & w_iord;
  assign mem_read_o      = rst_n & w_mem_read;
  assign mem_write_o     = rst_n & w_mem_write;
  assign ir_write_o      = rst_n & w_ir_write;
  assign reg_dst_o       = rst_n & w_reg_dst;
  assign mem_to_reg_o    = rst_n & w_mem_to_reg;
  assign reg_write_o     = rst_n & w_reg_write;
  assign alu_src_a_o     = rst_n & w_alu_src_a;
  assign alu_src_b_o     = rst_n ? w_alu_src_b : 2'b00;
  assign alu_op_o        = rst_n ? w_alu_op : 3'b000;
  assign instr_done_o    = rst_n & w_done;
  assign illegal_o       = rst_n & w_illegal;
  assign state_o         = rst_n ? r_state : 4'd0;
  assign retired_o       = r_retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each stimulus cycle queues its hand-derived
// control vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multi_cycle_ctrl;

  logic        clk_i, rst_n;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  logic        pc_write_o, pc_write_cond_o, branch_type_o, iord_o;
  logic        mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o;
  logic        reg_write_o, alu_src_a_o, instr_done_o, illegal_o;
  logic [1:0]  pc_source_o, alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  multi_cycle_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .branch_type_o(branch_type_o), .pc_source_o(pc_source_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .state_o(state_o),
    .retired_o(retired_o)
  );

  typedef struct {
    logic [23:0] ctl;
    logic [31:0] ret;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;
  logic [31:0] exp_ret = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Field order: state, illegal, done, alu_op, src_b, src_a, reg_write, mem_to_reg,
  // reg_dst, ir_write, mem_write, mem_read, iord, pc_source, branch_type, pc_write_cond, pc_write
  function automatic logic [23:0] mk(input logic [3:0] st, input logic ill, input logic dn,
      input logic [2:0] aop, input logic [1:0] sb, input logic sa, input logic rw,
      input logic m2r, input logic rd, input logic irw, input logic mw, input logic mr,
      input logic io, input logic [1:0] ps, input logic bt, input logic pwc, input logic pw);
    return {st, ill, dn, aop, sb, sa, rw, m2r, rd, irw, mw, mr, io, ps, bt, pwc, pw};
  endfunction

  logic [23:0] E_ZERO, E_F_RDY, E_F_WAIT, E_DEC, E_MA, E_MRD, E_MWB, E_MWR_W, E_MWR_R;
  logic [23:0] E_REX, E_RWB, E_BNE, E_BEQ, E_J, E_ADDI, E_LUI, E_IWB, E_TRAP;

  // One cycle: drive inputs just after the edge and queue what this cycle must show
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [23:0] e);
    exp_t x;
    @(posedge clk_i);
    #1;
    rst_n       = rst;
    instr_op_i  = op;
    mem_ready_i = rdy;
    if (!rst) exp_ret = 0;
    x.ctl = e;
    x.ret = exp_ret;
    x.idx = step_no;
    q.push_back(x);
    step_no++;
    if (e[18]) exp_ret = exp_ret + 32'd1;
  endtask

  // Monitor: compare the queued expectation against the live outputs mid-cycle
  always @(negedge clk_i) begin
    exp_t x;
    logic [23:0] act;
    if (q.size() > 0) begin
      x = q.pop_front();
      act = {state_o, illegal_o, instr_done_o, alu_op_o, alu_src_b_o, alu_src_a_o,
             reg_write_o, mem_to_reg_o, reg_dst_o, ir_write_o, mem_write_o, mem_read_o,
             iord_o, pc_source_o, branch_type_o, pc_write_cond_o, pc_write_o};
      n_checks++;
      if (act !== x.ctl) begin
        n_errors++;
        $display("FAIL ctl step %0d: got %h expected %h (state got %0d expected %0d)",
                 x.idx, act, x.ctl, act[23:20], x.ctl[23:20]);
      end
      n_checks++;
      if (retired_o !== x.ret) begin
        n_errors++;
        $display("FAIL retired step %0d: got %0d expected %0d", x.idx, retired_o, x.ret);
      end
    end
  end

  initial begin
    rst_n = 1'b0; instr_op_i = 6'd0; mem_ready_i = 1'b1;
    //            st  il dn aop   sb    sa rw m2r rd irw mw mr io ps    bt pwc pw
    E_ZERO   = '0;
    E_F_RDY  = mk(0, 0, 0, 3'd0, 2'd1, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0, 1);
    E_F_WAIT = mk(0, 0, 0, 3'd0, 2'd1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0);
    E_DEC    = mk(1, 0, 0, 3'd0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_MA     = mk(2, 0, 0, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_MRD    = mk(3, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0);
    E_MWB    = mk(4, 0, 1, 3'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_MWR_W  = mk(5, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 0, 0, 0);
    E_MWR_R  = mk(5, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 0, 0, 0);
    E_REX    = mk(6, 0, 0, 3'd2, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_RWB    = mk(7, 0, 1, 3'd0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_BNE    = mk(8, 0, 1, 3'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1, 1, 0);
    E_BEQ    = mk(8, 0, 1, 3'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 1, 0);
    E_J      = mk(9, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1);
    E_ADDI   = mk(10, 0, 0, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_LUI    = mk(10, 0, 0, 3'd3, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_IWB    = mk(11, 0, 1, 3'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    E_TRAP   = mk(12, 1, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);

    // Reset held: everything low, counter zero
    repeat (3) step(0, 6'h00, 1, E_ZERO);
    // R-type with a changing opcode after DECODE that must be ignored
    step(1, 6'b000000, 1, E_F_RDY);
    step(1, 6'b000000, 1, E_DEC);
    step(1, 6'b111111, 1, E_REX);
    step(1, 6'b100011, 0, E_RWB);
    // lw with two wait cycles in MEM_RD, plus one FETCH wait
    step(1, 6'b100011, 0, E_F_WAIT);
    step(1, 6'b100011, 1, E_F_RDY);
    step(1, 6'b100011, 0, E_DEC);
    step(1, 6'b100011, 1, E_MA);
    step(1, 6'b100011, 0, E_MRD);
    step(1, 6'b100011, 0, E_MRD);
    step(1, 6'b100011, 1, E_MRD);
    step(1, 6'b000000, 0, E_MWB);
    // sw with one wait in MEM_WR
    step(1, 6'b101011, 1, E_F_RDY);
    step(1, 6'b101011, 1, E_DEC);
    step(1, 6'b101011, 1, E_MA);
    step(1, 6'b101011, 0, E_MWR_W);
    step(1, 6'b101011, 1, E_MWR_R);
    // addi and lui
    step(1, 6'b001000, 1, E_F_RDY);
    step(1, 6'b001000, 1, E_DEC);
    step(1, 6'b001111, 1, E_ADDI);
    step(1, 6'b001111, 1, E_IWB);
    step(1, 6'b001111, 1, E_F_RDY);
    step(1, 6'b001111, 1, E_DEC);
    step(1, 6'b001000, 1, E_LUI);
    step(1, 6'b001000, 1, E_IWB);
    // bne, beq, j
    step(1, 6'b000101, 1, E_F_RDY);
    step(1, 6'b000101, 1, E_DEC);
    step(1, 6'b000100, 1, E_BNE);
    step(1, 6'b000100, 1, E_F_RDY);
    step(1, 6'b000100, 1, E_DEC);
    step(1, 6'b000101, 1, E_BEQ);
    step(1, 6'b000010, 1, E_F_RDY);
    step(1, 6'b000010, 1, E_DEC);
    step(1, 6'b000010, 1, E_J);
    // Reset asserted mid-cycle during a stalled write: strobes drop before any edge
    step(1, 6'b101011, 1, E_F_RDY);
    step(1, 6'b101011, 1, E_DEC);
    step(1, 6'b101011, 1, E_MA);
    step(1, 6'b101011, 0, E_MWR_W);
    step(0, 6'b101011, 0, E_ZERO);
    step(0, 6'b101011, 1, E_ZERO);
    step(1, 6'b000010, 1, E_F_RDY);
    step(1, 6'b000010, 1, E_DEC);
    step(1, 6'b000010, 1, E_J);
    // Illegal opcode traps; nothing retires until reset
    step(1, 6'b111111, 1, E_F_RDY);
    step(1, 6'b111111, 1, E_DEC);
    for (int i = 0; i < 11; i++) step(1, 6'(i), 1'(i % 2), E_TRAP);
    step(0, 6'b000000, 1, E_ZERO);
    step(1, 6'b000000, 1, E_F_RDY);
    step(1, 6'b000000, 1, E_DEC);
    step(1, 6'b000000, 1, E_REX);
    step(1, 6'b000000, 1, E_RWB);

    // Drain with a bounded wait
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk_i);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
